// File: rtl/pixel_gamma_pipe_pkg.sv
// Shared definitions for the pixel gamma/brightness write-path pipeline.
// Contents: channel field indices and their bit-offset helper,
//           LUT select encodings, pipeline latency.
package pixel_gamma_pipe_pkg;

  // Channel field positions inside the packed pixel word, counted in
  // channel-width units; ch_offset() turns them into bit offsets.
  localparam int unsigned CH_R_FIELD = 0;
  localparam int unsigned CH_G_FIELD = 1;
  localparam int unsigned CH_B_FIELD = 2;
  localparam int unsigned N_CH       = 3;

  // LUT select encoding. The channel index equals its select value.
  typedef enum logic [1:0] {
    LUT_R    = 2'd0,
    LUT_G    = 2'd1,
    LUT_B    = 2'd2,
    LUT_NONE = 2'd3
  } lut_sel_e;

  localparam int unsigned PIPE_LATENCY = 3;

  function automatic int unsigned ch_offset(input int unsigned ch,
                                            input int unsigned bitdepth);
    return ch * bitdepth;
  endfunction

endpackage

// File: rtl/gamma_lut.sv
// Single-channel gamma LUT: 2**BITDEPTH_MAX x BITDEPTH_MAX simple dual-port
// RAM with a synchronous read-first read port. Contents are not reset.
// Ports:
//   clk           clock
//   we/waddr/wdata  write port (single cycle)
//   raddr/rdata     synchronous read port, data valid the cycle after raddr
module gamma_lut #(
  parameter int unsigned BITDEPTH_MAX = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [BITDEPTH_MAX-1:0] waddr,
  input  logic [BITDEPTH_MAX-1:0] wdata,
  input  logic [BITDEPTH_MAX-1:0] raddr,
  output logic [BITDEPTH_MAX-1:0] rdata
);

  logic [BITDEPTH_MAX-1:0] mem [2**BITDEPTH_MAX];

  // Read and write share one clocked block, so a same-entry collision
  // returns the value held before the write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pixel_gamma_pipe.sv
// Pipelined per-channel gamma correction and global brightness scaling on
// the framebuffer write path. Fixed 3-cycle latency, one pixel per cycle.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   i_we/i_waddr/i_wdata/i_wstrb   incoming pixel write
//   ctrl_bypass           skip LUT and scaling (sampled with each pixel)
//   ctrl_brightness       scale factor, out = v*(brightness+1)>>8
//   lut_we/lut_sel/lut_addr/lut_data   LUT load port (sel 3 = no write)
//   o_we/o_waddr/o_wdata/o_wstrb   corrected framebuffer write
//   o_busy                any pipeline stage holds a pixel
//   o_pix_count           number of pixels emitted, wraps at 2**32
module pixel_gamma_pipe
  import pixel_gamma_pipe_pkg::*;
#(
  parameter int unsigned BITDEPTH_MAX = 8,
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_we,
  input  logic [ADDR_WIDTH-1:0]   i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    ctrl_bypass,
  input  logic [7:0]              ctrl_brightness,
  input  logic                    lut_we,
  input  logic [1:0]              lut_sel,
  input  logic [BITDEPTH_MAX-1:0] lut_addr,
  input  logic [BITDEPTH_MAX-1:0] lut_data,
  output logic                    o_we,
  output logic [ADDR_WIDTH-1:0]   o_waddr,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [DATA_WIDTH/8-1:0] o_wstrb,
  output logic                    o_busy,
  output logic [31:0]             o_pix_count
);

  localparam int unsigned B      = BITDEPTH_MAX;
  localparam int unsigned PROD_W = 8 + B + 1;
  localparam int unsigned SW     = DATA_WIDTH / 8;

  logic [B-1:0]      in_ch   [N_CH];
  logic [B-1:0]      lut_q   [N_CH];

  logic              s1_valid;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [SW-1:0]     s1_strb;
  logic              s1_bypass;
  logic [7:0]        s1_bright;
  logic [B-1:0]      s1_raw  [N_CH];

  logic [8:0]        factor;
  logic [PROD_W-1:0] prod_next [N_CH];

  logic              s2_valid;
  logic [ADDR_WIDTH-1:0] s2_addr;
  logic [SW-1:0]     s2_strb;
  logic [PROD_W-1:0] s2_prod [N_CH];

  logic [DATA_WIDTH-1:0] wdata_next;

  // Channel extraction; unused upper pixel bits are dropped here.
  always_comb begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      in_ch[c] = B'(i_wdata >> ch_offset(c, B));
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_lut
    gamma_lut #(.BITDEPTH_MAX(B)) u_lut (
      .clk   (clk),
      .we    (lut_we && (lut_sel == 2'(ch))),
      .waddr (lut_addr),
      .wdata (lut_data),
      .raddr (in_ch[ch]),
      .rdata (lut_q[ch])
    );
  end

  // S1: register the pixel alongside the LUT reads it issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      s1_strb   <= '0;
      s1_bypass <= 1'b0;
      s1_bright <= '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        s1_raw[c] <= '0;
      end
    end else begin
      s1_valid  <= i_we;
      s1_addr   <= i_waddr;
      s1_strb   <= i_wstrb;
      s1_bypass <= ctrl_bypass;
      s1_bright <= ctrl_brightness;
      for (int unsigned c = 0; c < N_CH; c++) begin
        s1_raw[c] <= in_ch[c];
      end
    end
  end

  // S2 multiply. Bypass uses a factor of 256 so the common >>8 in S3 returns
  // the raw channel unchanged, keeping a single datapath for both modes.
  always_comb begin
    factor = s1_bypass ? 9'd256 : ({1'b0, s1_bright} + 9'd1);
    for (int unsigned c = 0; c < N_CH; c++) begin
      prod_next[c] = PROD_W'(s1_bypass ? s1_raw[c] : lut_q[c]) * PROD_W'(factor);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_addr  <= '0;
      s2_strb  <= '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        s2_prod[c] <= '0;
      end
    end else begin
      s2_valid <= s1_valid;
      s2_addr  <= s1_addr;
      s2_strb  <= s1_strb;
      for (int unsigned c = 0; c < N_CH; c++) begin
        s2_prod[c] <= prod_next[c];
      end
    end
  end

  // S3: scale back down and repack; upper word bits stay zero.
  always_comb begin
    wdata_next = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      wdata_next[ch_offset(c, B) +: B] = B'(s2_prod[c] >> 8);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_we    <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
      o_wstrb <= '0;
    end else begin
      o_we <= s2_valid;
      if (s2_valid) begin
        o_waddr <= s2_addr;
        o_wdata <= wdata_next;
        o_wstrb <= s2_strb;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_pix_count <= '0;
    end else if (o_we) begin
      o_pix_count <= o_pix_count + 32'd1;
    end
  end

  assign o_busy = s1_valid | s2_valid | o_we;

endmodule

// File: tb/tb_pixel_gamma_pipe.sv
module tb_pixel_gamma_pipe;
  import pixel_gamma_pipe_pkg::*;

  localparam int unsigned B  = 8;
  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_we = 1'b0;
  logic [AW-1:0] i_waddr = '0;
  logic [DW-1:0] i_wdata = '0;
  logic [SW-1:0] i_wstrb = '0;
  logic          ctrl_bypass = 1'b1;
  logic [7:0]    ctrl_brightness = 8'hFF;
  logic          lut_we = 1'b0;
  logic [1:0]    lut_sel = '0;
  logic [B-1:0]  lut_addr = '0;
  logic [B-1:0]  lut_data = '0;
  logic          o_we;
  logic [AW-1:0] o_waddr;
  logic [DW-1:0] o_wdata;
  logic [SW-1:0] o_wstrb;
  logic          o_busy;
  logic [31:0]   o_pix_count;

  pixel_gamma_pipe #(
    .BITDEPTH_MAX (B),
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_we            (i_we),
    .i_waddr         (i_waddr),
    .i_wdata         (i_wdata),
    .i_wstrb         (i_wstrb),
    .ctrl_bypass     (ctrl_bypass),
    .ctrl_brightness (ctrl_brightness),
    .lut_we          (lut_we),
    .lut_sel         (lut_sel),
    .lut_addr        (lut_addr),
    .lut_data        (lut_data),
    .o_we            (o_we),
    .o_waddr         (o_waddr),
    .o_wdata         (o_wdata),
    .o_wstrb         (o_wstrb),
    .o_busy          (o_busy),
    .o_pix_count     (o_pix_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   due;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } exp_t;

  int unsigned   n_checks = 0;
  int unsigned   n_pass   = 0;
  int unsigned   cyc      = 0;
  int unsigned   lut_m [3][256];
  exp_t          q [$];
  int unsigned   model_count = 0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_data = '0;
  logic [SW-1:0] last_strb = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference: look up each channel, then scale by (brightness+1)/256.
  function automatic logic [DW-1:0] ref_pixel(input logic [DW-1:0] d, input bit byp,
                                              input int unsigned bright);
    logic [DW-1:0] r = '0;
    for (int c = 0; c < 3; c++) begin
      int unsigned v = (d >> (8 * c)) & 32'hFF;
      if (!byp) v = (lut_m[c][v] * (bright + 1)) / 256;
      r[8*c +: 8] = 8'(v);
    end
    return r;
  endfunction

  task automatic clear_model();
    q.delete();
    model_count = 0;
    last_addr = '0;
    last_data = '0;
    last_strb = '0;
  endtask

  // One clock: check every output against the model, then release strobes.
  task automatic step();
    bit   exp_we;
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    exp_we = (q.size() > 0) && (q[0].due == cyc);
    check("busy", o_busy, q.size() > 0);
    check("pix_count", o_pix_count, model_count);
    check("we", o_we, exp_we);
    if (exp_we) begin
      e = q.pop_front();
      last_addr = e.addr;
      last_data = e.data;
      last_strb = e.strb;
      model_count++;
    end
    check("waddr", o_waddr, last_addr);
    check("wdata", o_wdata, last_data);
    check("wstrb", o_wstrb, last_strb);
    i_we   = 1'b0;
    lut_we = 1'b0;
  endtask

  task automatic drive_pix(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, input bit byp, input logic [7:0] br);
    exp_t e;
    i_we = 1'b1;
    i_waddr = a;
    i_wdata = d;
    i_wstrb = s;
    ctrl_bypass = byp;
    ctrl_brightness = br;
    e.due  = cyc + PIPE_LATENCY;
    e.addr = a;
    e.data = ref_pixel(d, byp, br);
    e.strb = s;
    q.push_back(e);
  endtask

  // Call after drive_pix in the same cycle: the model update lands after the
  // pixel's lookup, matching read-first behaviour.
  task automatic lut_wr(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] d);
    lut_we = 1'b1;
    lut_sel = sel;
    lut_addr = a;
    lut_data = d;
    if (sel != 2'd3) lut_m[sel][a] = d;
  endtask

  task automatic directed(input string tag, input logic [DW-1:0] d,
                          input logic [7:0] br, input logic [DW-1:0] want);
    drive_pix(AW'(16), d, 4'hF, 1'b0, br);
    step(); step(); step();
    check({tag, "_we"}, o_we, 1'b1);
    check({tag, "_addr"}, o_waddr, 14'h0010);
    check({tag, "_data"}, o_wdata, want);
  endtask

  initial begin
    clear_model();
    step(); step();
    rst = 1'b0;
    step();

    // Identity LUT load with bypassed pixels streaming alongside.
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 256; k++) begin
        if ($urandom_range(0, 1) == 1)
          drive_pix(AW'($urandom), $urandom, SW'($urandom), 1'b1, 8'($urandom));
        lut_wr(2'(s), 8'(k), 8'(k));
        step();
      end
    end
    repeat (4) step();

    directed("ident", 32'h00123456, 8'hFF, 32'h00123456);

    for (int k = 0; k < 256; k++) begin
      lut_wr(LUT_R, 8'(k), 8'(255 - k));
      step();
    end
    directed("inv_ff", 32'h000000FF, 8'hFF, 32'h00000000);
    directed("inv_00", 32'h00000000, 8'hFF, 32'h000000FF);

    for (int k = 0; k < 256; k++) begin
      lut_wr(LUT_R, 8'(k), 8'(k));
      step();
    end
    directed("bright127", 32'h00C88040, 8'd127, 32'h00644020);
    directed("bright0", 32'h00FFFFFF, 8'd0, 32'h00000000);

    // Same-cycle LUT write versus lookup, then an ignored select-3 write.
    drive_pix(AW'(1), 32'h00000005, 4'hF, 1'b0, 8'hFF);
    lut_wr(LUT_R, 8'h05, 8'hAA);
    step();
    drive_pix(AW'(2), 32'h00000005, 4'hF, 1'b0, 8'hFF);
    step();
    lut_wr(2'd3, 8'h05, 8'h11);
    step();
    check("rf_old", o_wdata, 32'h00000005);
    drive_pix(AW'(3), 32'h00050505, 4'hF, 1'b0, 8'hFF);
    step();
    check("rf_new", o_wdata, 32'h000000AA);
    repeat (2) step();
    check("sel3_none", o_wdata, 32'h000505AA);

    // Reset, then 1000 back-to-back bypassed pixels.
    rst = 1'b1;
    clear_model();
    step();
    rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      drive_pix(AW'($urandom), $urandom, SW'($urandom), 1'b1, 8'($urandom));
      step();
    end
    repeat (5) step();
    check("burst_count", o_pix_count, 32'd1000);
    check("burst_idle", o_busy, 1'b0);

    // Mixed random traffic with LUT writes, gaps and control changes.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) != 0)
        drive_pix(AW'($urandom), $urandom, SW'($urandom),
                  $urandom_range(0, 3) == 0, 8'($urandom));
      if ($urandom_range(0, 7) == 0)
        lut_wr(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      step();
    end
    repeat (5) step();

    // Asynchronous reset with two pixels in flight.
    drive_pix(AW'(7), 32'h00ABCDEF, 4'hF, 1'b0, 8'd200);
    step();
    drive_pix(AW'(8), 32'h00010203, 4'h3, 1'b1, 8'd10);
    step();
    #2 rst = 1'b1;
    #1;
    check("rst_we", o_we, 1'b0);
    check("rst_addr", o_waddr, '0);
    check("rst_data", o_wdata, '0);
    check("rst_strb", o_wstrb, '0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_count", o_pix_count, '0);
    clear_model();
    step(); step();
    rst = 1'b0;
    repeat (6) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
